cpu_fetch_unit: RTL

//  Prefetching instruction-fetch front end for the next-gen core; replaces single-word blocking fetch.

---
 rtl/cpu_fetch_unit_pkg.sv | 17 +
 rtl/cpu_fetch_unit_fetch_queue.sv | 50 +++++
 rtl/cpu_fetch_unit.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/cpu_fetch_unit_pkg.sv
// Shared definitions for the prefetching instruction-fetch front end.
package cpu_fetch_unit_pkg;

    localparam int unsigned CPU_XLEN = 32;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_e;

    function automatic logic resp_is_error(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/cpu_fetch_unit_fetch_queue.sv
// Synchronous FIFO with wrap-bit pointers; DEPTH must be a power of 2, >= 2.
module fetch_queue #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_Clock,
    input  logic                     w_Reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count     = wr_ptr - rd_ptr;
    assign do_pop    = pop && !empty;
    // a push into a full queue is legal only alongside a pop
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge i_Clock) begin
        if (w_Reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/cpu_fetch_unit.sv
// Prefetching AXI-Lite instruction fetch with credit-limited issue and redirect flush.
// Optional FETCH_PERF_COUNTERS_EN adds saturating fetch/redirect/empty-stall counters.
module cpu_fetch_unit
    import cpu_fetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN            = CPU_XLEN,
    parameter int unsigned     QUEUE_DEPTH     = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic            i_Clock,
    input  logic            w_Reset,
    input  logic            i_Enable,
    input  logic            i_Redirect_Valid,
    input  logic [XLEN-1:0] i_Redirect_PC,
    output logic            o_Instr_Valid,
    input  logic            i_Instr_Ready,
    output logic [XLEN-1:0] o_Instruction,
    output logic [XLEN-1:0] o_Instr_PC,
    output logic            o_Instr_Error,
    output logic [XLEN-1:0] m_axil_araddr,
    output logic            m_axil_arvalid,
    input  logic            m_axil_arready,
    input  logic [XLEN-1:0] m_axil_rdata,
    input  logic [1:0]      m_axil_rresp,
    input  logic            m_axil_rvalid,
    output logic            m_axil_rready
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]     o_Fetch_Count,
    output logic [31:0]     o_Redirect_Count,
    output logic [31:0]     o_Empty_Stall_Count
`endif
);

    localparam int unsigned   CW      = $clog2(QUEUE_DEPTH) + 1;
    localparam int unsigned   EW      = 2 * XLEN + 1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] MAX_OUT = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
    localparam logic [XLEN-1:0] PC_ALIGN = ~XLEN'(3);

    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   occupancy;
    logic [CW-1:0]   outstanding_next;
    logic [CW-1:0]   occupancy_next;
    logic            ar_hs;
    logic            r_hs;
    logic            pop_hs;
    logic            push_en;
    logic            issue;
    logic            pending_stale;
    logic            q_empty;
    logic            addr_empty;
    logic [EW-1:0]   q_head;
    logic [EW-1:0]   q_push_data;
    logic [XLEN-1:0] beat_pc;

    // Issued-address FIFO: its occupancy is exactly the outstanding read count.
    fetch_queue #(
        .WIDTH (XLEN),
        .DEPTH (QUEUE_DEPTH)
    ) u_addr_fifo (
        .i_Clock   (i_Clock),
        .w_Reset   (w_Reset),
        .flush     (1'b0),
        .push      (ar_hs),
        .push_data (m_axil_araddr),
        .pop       (r_hs),
        .head_data (beat_pc),
        .empty     (addr_empty),
        .count     (outstanding)
    );

    fetch_queue #(
        .WIDTH (EW),
        .DEPTH (QUEUE_DEPTH)
    ) u_instr_queue (
        .i_Clock   (i_Clock),
        .w_Reset   (w_Reset),
        .flush     (i_Redirect_Valid),
        .push      (push_en),
        .push_data (q_push_data),
        .pop       (pop_hs),
        .head_data (q_head),
        .empty     (q_empty),
        .count     (occupancy)
    );

    assign m_axil_rready = 1'b1;
    assign ar_hs         = m_axil_arvalid && m_axil_arready;
    assign r_hs          = m_axil_rvalid && !addr_empty;
    assign pending_stale = m_axil_arvalid && !m_axil_arready;
    assign pop_hs        = o_Instr_Valid && i_Instr_Ready && !i_Redirect_Valid;
    assign push_en       = r_hs && (discard == '0) && !i_Redirect_Valid;
    assign q_push_data   = {resp_is_error(m_axil_rresp), beat_pc, m_axil_rdata};

    assign o_Instr_Valid = !q_empty;
    assign o_Instruction = q_empty ? '0   : q_head[XLEN-1:0];
    assign o_Instr_PC    = q_empty ? '0   : q_head[2*XLEN-1:XLEN];
    assign o_Instr_Error = q_empty ? 1'b0 : q_head[2*XLEN];

    always_comb begin
        outstanding_next = outstanding + CW'(ar_hs) - CW'(r_hs);
        occupancy_next   = i_Redirect_Valid ? '0 : occupancy + CW'(push_en) - CW'(pop_hs);
        issue = i_Enable && !i_Redirect_Valid && (!m_axil_arvalid || ar_hs)
             && (outstanding_next < MAX_OUT)
             && ((outstanding_next + occupancy_next) < DEPTH_C);
    end

    // fetch_pc advances when an address is loaded into araddr rather than at the
    // handshake, so a stale AR completing after a redirect cannot disturb it.
    always_ff @(posedge i_Clock) begin
        if (w_Reset) begin
            m_axil_arvalid <= 1'b0;
            m_axil_araddr  <= '0;
            fetch_pc       <= RESET_PC;
            discard        <= '0;
        end else begin
            if (issue) begin
                m_axil_arvalid <= 1'b1;
                m_axil_araddr  <= fetch_pc;
                fetch_pc       <= fetch_pc + PC_STEP;
            end else if (ar_hs) begin
                m_axil_arvalid <= 1'b0;
            end
            if (i_Redirect_Valid) begin
                fetch_pc <= i_Redirect_PC & PC_ALIGN;
                discard  <= outstanding_next + CW'(pending_stale);
            end else if (r_hs && (discard != '0)) begin
                discard <= discard - CNT_ONE;
            end
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    always_ff @(posedge i_Clock) begin
        if (w_Reset) begin
            o_Fetch_Count       <= '0;
            o_Redirect_Count    <= '0;
            o_Empty_Stall_Count <= '0;
        end else begin
            if (pop_hs && (o_Fetch_Count != '1))
                o_Fetch_Count <= o_Fetch_Count + 32'd1;
            if (i_Redirect_Valid && (o_Redirect_Count != '1))
                o_Redirect_Count <= o_Redirect_Count + 32'd1;
            if (i_Instr_Ready && !o_Instr_Valid && (o_Empty_Stall_Count != '1))
                o_Empty_Stall_Count <= o_Empty_Stall_Count + 32'd1;
        end
    end
`endif

endmodule
